// File: rtl/vga_timing_pkg.sv
// Purpose: shared 640x480@60 timing constants for the raster scan and its overlay consumers.
// Latency: none (constants only).
// Backpressure: none; nothing in this package carries flow control.
//
// Contents: visible/porch/sync widths for both axes, their totals, the coordinate width
// and the default sync polarity.
`timescale 1ns/1ps
package vga_timing_pkg;

    localparam int COORD_W   = 10;
    localparam int DIV_W     = 4;       // wide enough for a pixel divider of up to 8

    localparam int H_DISPLAY = 640;
    localparam int H_FRONT   = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BACK    = 48;
    localparam int H_TOTAL   = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;   // 800

    localparam int V_DISPLAY = 480;
    localparam int V_FRONT   = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BACK    = 33;
    localparam int V_TOTAL   = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;   // 525

    // Active level of hsync/vsync: 0 means the pulses are active-low.
    localparam logic SYNC_POL = 1'b0;

endpackage

// File: rtl/mod_counter.sv
// Purpose: modulo-N up counter with enable, synchronous clear and a wrap strobe.
// Latency: count updates one clk after an enabled cycle; wrap is combinational from the register.
// Backpressure: none; advances whenever en is high.
//
// Ports: clk, rst_n (async active-low), en (advance), clr (sync clear, wins over en),
//        count (current value), wrap (en high while count is at its last value).
`timescale 1ns/1ps
module mod_counter #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    output logic [WIDTH-1:0] count,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

    logic at_last;

    // ">=" rather than "==" so a value forced out of range still returns to 0 on the
    // next enabled cycle instead of running on to the top of the register.
    generate
        if (MODULUS == 1) begin : g_single
            assign at_last = 1'b1;
        end else begin : g_multi
            assign at_last = (count >= LAST);
        end
    endgenerate

    assign wrap = en && at_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= at_last ? '0 : count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/vga_scan_generator.sv
// Purpose: raster scan generator - pixel-tick divider, x/y counters, sync/blank decode, frame strobe.
// Latency: x/y change on the clk edge of a pixel tick; syncs/video_on follow the same edge (one more tick with VGA_SYNC_DELAY_EN).
// Backpressure: none; free-running timing source.
//
// Ports: clk, reset_n (async active-low) in; pixel_tick, x, y, video_on, hsync, vsync,
//        frame_start out.
// Build option: define VGA_SYNC_DELAY_EN to register hsync/vsync/video_on one extra pixel,
// aligning them with overlays that register their RGB output. x/y/frame_start are unaffected.
`timescale 1ns/1ps
module vga_scan_generator #(
    parameter int   CLK_DIV   = 2,
    parameter int   H_DISPLAY = vga_timing_pkg::H_DISPLAY,
    parameter int   H_FRONT   = vga_timing_pkg::H_FRONT,
    parameter int   H_SYNC    = vga_timing_pkg::H_SYNC,
    parameter int   H_BACK    = vga_timing_pkg::H_BACK,
    parameter int   V_DISPLAY = vga_timing_pkg::V_DISPLAY,
    parameter int   V_FRONT   = vga_timing_pkg::V_FRONT,
    parameter int   V_SYNC    = vga_timing_pkg::V_SYNC,
    parameter int   V_BACK    = vga_timing_pkg::V_BACK,
    parameter logic SYNC_POL  = vga_timing_pkg::SYNC_POL
) (
    input  logic                               clk,
    input  logic                               reset_n,
    output logic                               pixel_tick,
    output logic [vga_timing_pkg::COORD_W-1:0] x,
    output logic [vga_timing_pkg::COORD_W-1:0] y,
    output logic                               video_on,
    output logic                               hsync,
    output logic                               vsync,
    output logic                               frame_start
);

    import vga_timing_pkg::*;

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    generate
        if (H_TOTAL > (1 << COORD_W) || V_TOTAL > (1 << COORD_W)) begin : g_bad_total
            $error("vga_scan_generator: H_TOTAL/V_TOTAL exceed the coordinate range");
        end
        if (CLK_DIV < 1 || CLK_DIV > 8) begin : g_bad_div
            $error("vga_scan_generator: CLK_DIV must be 1..8");
        end
    endgenerate

    localparam logic [COORD_W-1:0] H_VIS        = COORD_W'(H_DISPLAY);
    localparam logic [COORD_W-1:0] V_VIS        = COORD_W'(V_DISPLAY);
    localparam logic [COORD_W-1:0] H_SYNC_START = COORD_W'(H_DISPLAY + H_FRONT);
    localparam logic [COORD_W-1:0] H_SYNC_END   = COORD_W'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [COORD_W-1:0] V_SYNC_START = COORD_W'(V_DISPLAY + V_FRONT);
    localparam logic [COORD_W-1:0] V_SYNC_END   = COORD_W'(V_DISPLAY + V_FRONT + V_SYNC - 1);

    logic [DIV_W-1:0]   div_cnt;
    logic               div_wrap;
    logic [COORD_W-1:0] h_cnt;
    logic               h_wrap;
    logic [COORD_W-1:0] v_cnt;
    logic               v_wrap;
    logic               unused_div_cnt;

    // Divider: the wrap strobe is exactly (div_cnt == CLK_DIV-1), i.e. the pixel tick.
    mod_counter #(.WIDTH(DIV_W), .MODULUS(CLK_DIV)) u_div (
        .clk   (clk),
        .rst_n (reset_n),
        .en    (1'b1),
        .clr   (1'b0),
        .count (div_cnt),
        .wrap  (div_wrap)
    );

    mod_counter #(.WIDTH(COORD_W), .MODULUS(H_TOTAL)) u_h (
        .clk   (clk),
        .rst_n (reset_n),
        .en    (pixel_tick),
        .clr   (1'b0),
        .count (h_cnt),
        .wrap  (h_wrap)
    );

    // h_wrap already includes pixel_tick, so v steps exactly once per line.
    mod_counter #(.WIDTH(COORD_W), .MODULUS(V_TOTAL)) u_v (
        .clk   (clk),
        .rst_n (reset_n),
        .en    (pixel_tick && h_wrap),
        .clr   (1'b0),
        .count (v_cnt),
        .wrap  (v_wrap)
    );

    // The divider count only matters through its wrap strobe.
    assign unused_div_cnt = ^div_cnt;

    assign pixel_tick  = div_wrap;
    assign x           = h_cnt;
    assign y           = v_cnt;
    // v_wrap = tick && h at last && v at last: the tick that returns the scan to (0,0).
    assign frame_start = v_wrap;

    logic video_on_dec;
    logic hsync_dec;
    logic vsync_dec;

    assign video_on_dec = (h_cnt < H_VIS) && (v_cnt < V_VIS);
    assign hsync_dec    = ((h_cnt >= H_SYNC_START) && (h_cnt <= H_SYNC_END)) ? SYNC_POL : ~SYNC_POL;
    assign vsync_dec    = ((v_cnt >= V_SYNC_START) && (v_cnt <= V_SYNC_END)) ? SYNC_POL : ~SYNC_POL;

`ifdef VGA_SYNC_DELAY_EN
    logic video_on_q;
    logic hsync_q;
    logic vsync_q;

    // Captures the decode of the pixel being left, so these lag x/y by one pixel.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            video_on_q <= 1'b1;
            hsync_q    <= ~SYNC_POL;
            vsync_q    <= ~SYNC_POL;
        end else if (pixel_tick) begin
            video_on_q <= video_on_dec;
            hsync_q    <= hsync_dec;
            vsync_q    <= vsync_dec;
        end
    end

    assign video_on = video_on_q;
    assign hsync    = hsync_q;
    assign vsync    = vsync_q;
`else
    assign video_on = video_on_dec;
    assign hsync    = hsync_dec;
    assign vsync    = vsync_dec;
`endif

endmodule

// File: tb/tb_vga_scan_generator.sv
`timescale 1ns/1ps
module tb_vga_scan_generator;

`ifdef VGA_SYNC_DELAY_EN
    localparam int LAG = 1;
`else
    localparam int LAG = 0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a_n;
    logic       rst_b_n;

    logic       a_tick, a_von, a_hs, a_vs, a_fs;
    logic [9:0] a_x, a_y;
    logic       b_tick, b_von, b_hs, b_vs, b_fs;
    logic [9:0] b_x, b_y;

    int n_pass  = 0;
    int n_total = 0;

    // Default 640x480 timing, pixel every 2 clks, active-low syncs.
    vga_scan_generator dut_a (
        .clk         (clk),
        .reset_n     (rst_a_n),
        .pixel_tick  (a_tick),
        .x           (a_x),
        .y           (a_y),
        .video_on    (a_von),
        .hsync       (a_hs),
        .vsync       (a_vs),
        .frame_start (a_fs)
    );

    // Tiny 16x8 frame, pixel every clk, active-high syncs: hsync x=10..12, vsync y=5..6.
    vga_scan_generator #(
        .CLK_DIV(1), .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
        .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1), .SYNC_POL(1'b1)
    ) dut_b (
        .clk         (clk),
        .reset_n     (rst_b_n),
        .pixel_tick  (b_tick),
        .x           (b_x),
        .y           (b_y),
        .video_on    (b_von),
        .hsync       (b_hs),
        .vsync       (b_vs),
        .frame_start (b_fs)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_a_n = 1'b0;
        rst_b_n = 1'b0;
        repeat (3) step();
        n_total++;
        if ({a_x, a_y} !== 20'd0) $display("FAIL reset_xy: got x=%0d y=%0d want 0 0", a_x, a_y);
        else n_pass++;
        n_total++;
        if (a_von !== 1'b1) $display("FAIL reset_video_on: got %b want 1", a_von);
        else n_pass++;
        n_total++;
        if ({a_hs, a_vs} !== 2'b11) $display("FAIL reset_syncs: got hs=%b vs=%b want 1 1", a_hs, a_vs);
        else n_pass++;
        n_total++;
        if ({a_fs, a_tick} !== 2'b00) $display("FAIL reset_strobes: got fs=%b tick=%b want 0 0", a_fs, a_tick);
        else n_pass++;
        @(negedge clk);
        rst_a_n = 1'b1;
        step();
        n_total++;
        if ({a_tick, a_x} !== {1'b1, 10'd0}) $display("FAIL first_tick: got tick=%b x=%0d want 1 0", a_tick, a_x);
        else n_pass++;
        step();
        n_total++;
        if ({a_tick, a_x} !== {1'b0, 10'd1}) $display("FAIL first_advance: got tick=%b x=%0d want 0 1", a_tick, a_x);
        else n_pass++;
    endtask

    task automatic test_line();
        int wrap_cyc[$];
        int wrap_y[$];
        int hs_low = 0, von_hi = 0, hs_fall = -1, von_fall = -1, vs_bad = 0, max_x = 0;
        logic [9:0] prev_x = a_x;
        logic prev_hs = a_hs, prev_von = a_von;
        for (int cyc = 1; cyc <= 4000 && wrap_cyc.size() < 2; cyc++) begin
            step();
            if (a_x == 10'd0 && prev_x != 10'd0) begin
                wrap_cyc.push_back(cyc);
                wrap_y.push_back(int'(a_y));
            end
            if (a_y == 10'd1) begin
                if (a_tick && !a_hs) hs_low++;
                if (a_tick && a_von) von_hi++;
                if (prev_hs && !a_hs && hs_fall < 0) hs_fall = int'(a_x);
                if (prev_von && !a_von && von_fall < 0) von_fall = int'(a_x);
            end
            if (a_vs !== 1'b1) vs_bad++;
            if (int'(a_x) > max_x) max_x = int'(a_x);
            prev_x   = a_x;
            prev_hs  = a_hs;
            prev_von = a_von;
        end
        n_total++;
        if (wrap_cyc.size() != 2) begin
            $display("FAIL line_wraps: got %0d line wraps within 4000 clks want 2", wrap_cyc.size());
        end else begin
            n_pass++;
            n_total++;
            if (wrap_cyc[1] - wrap_cyc[0] != 1600) $display("FAIL line_period: got %0d clks want 1600", wrap_cyc[1] - wrap_cyc[0]);
            else n_pass++;
            n_total++;
            if (wrap_y[0] != 1 || wrap_y[1] != 2) $display("FAIL line_y_step: got y=%0d,%0d want 1,2", wrap_y[0], wrap_y[1]);
            else n_pass++;
        end
        n_total++;
        if (hs_low != 96) $display("FAIL hsync_width: got %0d ticks want 96", hs_low);
        else n_pass++;
        n_total++;
        if (hs_fall != 656 + LAG) $display("FAIL hsync_start: got x=%0d want %0d", hs_fall, 656 + LAG);
        else n_pass++;
        n_total++;
        if (von_fall != 640 + LAG) $display("FAIL video_on_fall: got x=%0d want %0d", von_fall, 640 + LAG);
        else n_pass++;
        n_total++;
        if (von_hi != 640) $display("FAIL video_on_width: got %0d ticks want 640", von_hi);
        else n_pass++;
        n_total++;
        if (max_x != 799) $display("FAIL max_x: got %0d want 799", max_x);
        else n_pass++;
        n_total++;
        if (vs_bad != 0) $display("FAIL vsync_idle: got %0d active samples want 0", vs_bad);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        bit found = 1'b0;
        for (int i = 0; i < 3000 && !found; i++) begin
            step();
            if (a_x == 10'd300 && a_y == 10'd2) found = 1'b1;
        end
        n_total++;
        if (!found) begin
            $display("FAIL midreset_reach: got x=%0d y=%0d want 300 2", a_x, a_y);
            return;
        end
        n_pass++;
        #3;
        rst_a_n = 1'b0;
        #1;
        n_total++;
        if ({a_x, a_y, a_tick} !== 21'd0) $display("FAIL midreset_async_xy: got x=%0d y=%0d tick=%b want 0 0 0", a_x, a_y, a_tick);
        else n_pass++;
        n_total++;
        if ({a_von, a_hs, a_vs, a_fs} !== 4'b1110) $display("FAIL midreset_async_out: got von=%b hs=%b vs=%b fs=%b want 1 1 1 0", a_von, a_hs, a_vs, a_fs);
        else n_pass++;
        repeat (3) @(posedge clk);
        #2;
        rst_a_n = 1'b1;
        step();
        n_total++;
        if ({a_tick, a_x} !== {1'b1, 10'd0}) $display("FAIL midreset_tick: got tick=%b x=%0d want 1 0", a_tick, a_x);
        else n_pass++;
        step();
        n_total++;
        if ({a_x, a_y} !== {10'd1, 10'd0}) $display("FAIL midreset_restart: got x=%0d y=%0d want 1 0", a_x, a_y);
        else n_pass++;
    endtask

    task automatic test_clkdiv1();
        int tick_bad = 0, hs_bad = 0, vs_bad = 0, von_bad = 0, fs_pos_bad = 0;
        int fs_cyc[$];
        int px, py;
        logic e_hs, e_vs, e_von;
        n_total++;
        if ({b_tick, b_hs, b_vs, b_von} !== 4'b1001) $display("FAIL b_reset: got tick=%b hs=%b vs=%b von=%b want 1 0 0 1", b_tick, b_hs, b_vs, b_von);
        else n_pass++;
        @(negedge clk);
        rst_b_n = 1'b1;
        step();
        n_total++;
        if ({b_x, b_y} !== {10'd1, 10'd0}) $display("FAIL b_first_advance: got x=%0d y=%0d want 1 0", b_x, b_y);
        else n_pass++;
        for (int cyc = 0; cyc < 300; cyc++) begin
            if (cyc > 0) step();
            px = int'(b_x);
            py = int'(b_y);
            if (LAG == 1) begin
                if (px == 0) begin
                    px = 15;
                    py = (py == 0) ? 7 : py - 1;
                end else begin
                    px = px - 1;
                end
            end
            e_hs  = (px >= 10 && px <= 12);
            e_vs  = (py >= 5 && py <= 6);
            e_von = (px < 8 && py < 4);
            if (b_tick !== 1'b1) tick_bad++;
            if (b_hs !== e_hs) hs_bad++;
            if (b_vs !== e_vs) vs_bad++;
            if (b_von !== e_von) von_bad++;
            if (b_fs === 1'b1) begin
                fs_cyc.push_back(cyc);
                if (b_x != 10'd15 || b_y != 10'd7) fs_pos_bad++;
            end
        end
        n_total++;
        if (tick_bad != 0) $display("FAIL b_tick_const: got %0d low samples want 0", tick_bad);
        else n_pass++;
        n_total++;
        if (hs_bad != 0) $display("FAIL b_hsync_pattern: got %0d wrong samples want 0", hs_bad);
        else n_pass++;
        n_total++;
        if (vs_bad != 0) $display("FAIL b_vsync_pattern: got %0d wrong samples want 0", vs_bad);
        else n_pass++;
        n_total++;
        if (von_bad != 0) $display("FAIL b_video_on_pattern: got %0d wrong samples want 0", von_bad);
        else n_pass++;
        n_total++;
        if (fs_pos_bad != 0) $display("FAIL b_frame_start_pos: got %0d pulses off (15,7) want 0", fs_pos_bad);
        else n_pass++;
        n_total++;
        if (fs_cyc.size() != 2) begin
            $display("FAIL b_frame_start_count: got %0d pulses want 2", fs_cyc.size());
        end else begin
            n_pass++;
            n_total++;
            if (fs_cyc[0] != 126 || fs_cyc[1] - fs_cyc[0] != 128)
                $display("FAIL b_frame_period: got first=%0d period=%0d want 126 128", fs_cyc[0], fs_cyc[1] - fs_cyc[0]);
            else n_pass++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_line();
        test_reset_mid();
        test_clkdiv1();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
